// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, ALU selects and state encoding shared by the ALU sequencer
package alu_seq_pkg;
   localparam logic [2:0] OP_MV  = 3'b000;
   localparam logic [2:0] OP_MVI = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;
   localparam logic [2:0] OP_AND = 3'b100;
   localparam logic [2:0] OP_NOT = 3'b101;
   localparam logic [1:0] SEL_ADD = 2'b00;
   localparam logic [1:0] SEL_SUB = 2'b01;
   localparam logic [1:0] SEL_AND = 2'b10;
   localparam logic [1:0] SEL_NOT = 2'b11;
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_EXEC  = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;
   function automatic logic [1:0] op_sel(input logic [2:0] op);
      return op == OP_ADD ? SEL_ADD : op == OP_SUB ? SEL_SUB : op == OP_AND ? SEL_AND : SEL_NOT;
   endfunction
endpackage

// File: rtl/regfile4x4.sv
// regfile4x4: four 4-bit registers, two combinational read ports, one synchronous write port
module regfile4x4 (
   input  logic       clk,
   input  logic       rst,
   input  logic       we,
   input  logic [1:0] wa,
   input  logic [3:0] wd,
   input  logic [1:0] ra_x,
   input  logic [1:0] ra_y,
   output logic [3:0] rd_x,
   output logic [3:0] rd_y
);
   logic [3:0][3:0] r;
   // clear on reset, otherwise write the addressed register when enabled
   always_ff @(posedge clk) begin
      if (rst) r <= '0;
      else if (we) r[wa] <= wd;
   end
   assign rd_x = r[ra_x];
   assign rd_y = r[ra_y];
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle instruction sequencer driving an external ALU; ALU_SEQ_FLAGS_EN builds the zero flag
module alu_sequencer
   import alu_seq_pkg::*;
(
   input  logic       Clock,
   input  logic       Reset,
   input  logic       Run,
   input  logic [7:0] Instr,
   input  logic [3:0] Din,
   output logic [3:0] AluA,
   output logic [3:0] AluB,
   output logic [1:0] AluS,
   input  logic [3:0] AluF,
   output logic       Busy,
   output logic       Done,
   output logic       Err,
   output logic [3:0] Result,
   output logic       Z
);
   logic [1:0] state;
   logic [2:0] op;
   logic [1:0] rx, ry;
   logic [3:0] din_q, rd_x, rd_y, wd;
   logic       err_q, we, is_alu, is_move, unused_bit;
   assign unused_bit = Instr[4];
   assign is_alu  = op >= OP_ADD && op <= OP_NOT;
   assign is_move = op == OP_MV || op == OP_MVI;
   assign we      = (state == S_FETCH && is_move) || state == S_EXEC;
   assign wd      = state == S_EXEC ? AluF : op == OP_MVI ? din_q : rd_y;
   assign Busy    = state == S_FETCH || state == S_EXEC;
   assign Done    = state == S_DONE;
   assign Err     = Done && err_q;
   regfile4x4 u_rf (
      .clk(Clock), .rst(Reset), .we(we), .wa(rx), .wd(wd),
      .ra_x(rx), .ra_y(ry), .rd_x(rd_x), .rd_y(rd_y)
   );
   // sequence IDLE/DONE -> FETCH -> (EXEC) -> DONE, latching the instruction on accept
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state  <= S_IDLE;
         op     <= '0;
         rx     <= '0;
         ry     <= '0;
         din_q  <= '0;
         err_q  <= 1'b0;
         AluA   <= '0;
         AluB   <= '0;
         AluS   <= '0;
         Result <= '0;
      end else begin
         if (state == S_IDLE || state == S_DONE) begin
            state <= Run ? S_FETCH : S_IDLE;
            if (Run) begin
               op    <= Instr[7:5];
               rx    <= Instr[3:2];
               ry    <= Instr[1:0];
               din_q <= Din;
               err_q <= 1'b0;
            end
         end else if (state == S_FETCH) begin
            state <= is_alu ? S_EXEC : S_DONE;
            err_q <= !is_alu && !is_move;
            if (is_alu) begin
               AluA <= rd_x;
               AluB <= rd_y;
               AluS <= op_sel(op);
            end
         end else state <= S_DONE;
         if (we) Result <= wd;
      end
   end
`ifdef ALU_SEQ_FLAGS_EN
   // zero flag follows every register write
   always_ff @(posedge Clock) begin
      if (Reset) Z <= 1'b0;
      else if (we) Z <= wd == 4'h0;
   end
`else
   assign Z = 1'b0;
`endif
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed-vector bench for alu_sequencer with a behavioural ALU model
module tb_alu_sequencer;
   logic       clk = 1'b0, rst = 1'b1, run = 1'b0;
   logic [7:0] instr = '0;
   logic [3:0] din = '0, alu_a, alu_b, alu_f, result;
   logic [1:0] alu_s;
   logic       busy, done, err, z;
   int         total = 0, bad = 0, cyc, busy_n, dn;
   localparam logic [2:0] MV = 3'b000, MVI = 3'b001, ADD = 3'b010, SUB = 3'b011, AND_ = 3'b100, NOT_ = 3'b101;
`ifdef ALU_SEQ_FLAGS_EN
   localparam logic FLAGS = 1'b1;
`else
   localparam logic FLAGS = 1'b0;
`endif
   always #5 clk = ~clk;
   assign alu_f = alu_s == 2'b00 ? alu_a + alu_b : alu_s == 2'b01 ? alu_a - alu_b :
                  alu_s == 2'b10 ? alu_a & alu_b : {3'b000, alu_a == 4'h0};
   alu_sequencer dut (
      .Clock(clk), .Reset(rst), .Run(run), .Instr(instr), .Din(din),
      .AluA(alu_a), .AluB(alu_b), .AluS(alu_s), .AluF(alu_f),
      .Busy(busy), .Done(done), .Err(err), .Result(result), .Z(z)
   );
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic exec(input string tag, input logic [2:0] op, input logic [1:0] rx, input logic [1:0] ry,
                       input logic [3:0] d, input int exp_cyc, input logic [3:0] exp_res, input logic exp_err);
      run = 1'b1;
      instr = {op, 1'b0, rx, ry};
      din = d;
      @(negedge clk);
      run = 1'b0;
      instr = 8'hff;
      cyc = 1;
      busy_n = 0;
      while (!done && cyc < 10) begin
         if (busy) busy_n++;
         @(negedge clk);
         cyc++;
      end
      check({tag, "_cyc"}, cyc, exp_cyc);
      check({tag, "_res"}, result, exp_res);
      check({tag, "_err"}, err, exp_err);
   endtask
   initial begin
      repeat (2) @(negedge clk);
      check("rst_result", result, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_z", z, 0);
      check("rst_alua", alu_a, 0);
      check("rst_alus", alu_s, 0);
      rst = 1'b0;
      @(negedge clk);
      exec("mvi_r1", MVI, 2'd1, 2'd0, 4'h5, 2, 4'h5, 0);
      check("mvi_busy", busy_n, 1);
      exec("mvi_r2", MVI, 2'd2, 2'd0, 4'h3, 2, 4'h3, 0);
      exec("add", ADD, 2'd1, 2'd2, 4'h0, 3, 4'h8, 0);
      check("add_busy", busy_n, 2);
      check("add_alus", alu_s, 2'b00);
      check("add_alua", alu_a, 4'h5);
      check("add_alub", alu_b, 4'h3);
      exec("mvi_r1b", MVI, 2'd1, 2'd0, 4'h3, 2, 4'h3, 0);
      exec("mvi_r2b", MVI, 2'd2, 2'd0, 4'h5, 2, 4'h5, 0);
      exec("sub", SUB, 2'd1, 2'd2, 4'h0, 3, 4'hE, 0);
      check("sub_alus", alu_s, 2'b01);
      exec("and", AND_, 2'd1, 2'd2, 4'h0, 3, 4'h4, 0);
      check("and_alus", alu_s, 2'b10);
      check("and_z", z, 0);
      exec("not0", NOT_, 2'd3, 2'd0, 4'h0, 3, 4'h1, 0);
      check("not_alus", alu_s, 2'b11);
      exec("not1", NOT_, 2'd3, 2'd0, 4'h0, 3, 4'h0, 0);
      check("not_z", z, FLAGS);
      exec("ill110", 3'b110, 2'd1, 2'd2, 4'h9, 2, 4'h0, 1);
      exec("ill111", 3'b111, 2'd2, 2'd1, 4'h9, 2, 4'h0, 1);
      exec("mv_r1", MV, 2'd0, 2'd1, 4'h0, 2, 4'h4, 0);
      exec("mv_r2", MV, 2'd0, 2'd2, 4'h0, 2, 4'h5, 0);
      exec("mv_r3", MV, 2'd0, 2'd3, 4'h0, 2, 4'h0, 0);
      exec("sub_same", SUB, 2'd2, 2'd2, 4'h0, 3, 4'h0, 0);
      exec("mvi_r2c", MVI, 2'd2, 2'd0, 4'h5, 2, 4'h5, 0);
      run = 1'b1;
      instr = {ADD, 1'b0, 2'd1, 2'd2};
      @(negedge clk);
      check("ign_fetch_busy", busy, 1);
      instr = {3'b110, 5'd0};
      @(negedge clk);
      check("ign_exec_busy", busy, 1);
      run = 1'b0;
      @(negedge clk);
      check("ign_done", done, 1);
      check("ign_res", result, 4'h9);
      dn = 0;
      repeat (4) begin
         @(negedge clk);
         if (done) dn++;
      end
      check("ign_extra_done", dn, 0);
      run = 1'b1;
      instr = {MVI, 1'b0, 2'd3, 2'd0};
      din = 4'h7;
      @(negedge clk);
      instr = {NOT_, 1'b0, 2'd3, 2'd0};
      @(negedge clk);
      check("b2b_done1", done, 1);
      check("b2b_res1", result, 4'h7);
      @(negedge clk);
      check("b2b_fetch", busy, 1);
      check("b2b_nodone", done, 0);
      run = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("b2b_done2", done, 1);
      check("b2b_res2", result, 4'h0);
      @(negedge clk);
      exec("mv_pre", MV, 2'd0, 2'd2, 4'h0, 2, 4'h5, 0);
      run = 1'b1;
      instr = {ADD, 1'b0, 2'd1, 2'd2};
      @(negedge clk);
      run = 1'b0;
      @(negedge clk);
      check("rx_exec_busy", busy, 1);
      check("rx_exec_alua", alu_a, 4'h9);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rx_busy", busy, 0);
      check("rx_done", done, 0);
      check("rx_result", result, 0);
      check("rx_alua", alu_a, 0);
      check("rx_alub", alu_b, 0);
      check("rx_alus", alu_s, 0);
      check("rx_z", z, 0);
      @(negedge clk);
      check("rx_done2", done, 0);
      exec("rx_r1", MVI, 2'd0, 2'd0, 4'hA, 2, 4'hA, 0);
      exec("rx_mv1", MV, 2'd0, 2'd1, 4'h0, 2, 4'h0, 0);
      exec("rx_mv2", MV, 2'd0, 2'd2, 4'h0, 2, 4'h0, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle instruction sequencer for the 4-bit processor. It owns a 4x4-bit register file and drives the combinational ALU's operand and select inputs (A, B, S), capturing its result F. It accepts one instruction at a time through a Run/Done handshake and writes each result back to the destination register. It sits between the instruction source (switches or a fetch unit) and the ALU.

## Interface
Parameters:
- None. Widths are fixed: 4-bit data, 4 registers, 3-bit opcode.

Ports:
- Clock  in  1  single clock; all state changes on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Run  in  1  instruction request; sampled only when accepting (see Operation).
- Instr  in  8  [7:5] opcode, [4] unused, [3:2] Rx (destination/first operand), [1:0] Ry (second operand).
- Din  in  4  immediate for MVI, captured with Instr.
- AluA  out  4  registered ALU operand A.
- AluB  out  4  registered ALU operand B.
- AluS  out  2  registered ALU select: 00 add, 01 sub, 10 and, 11 not.
- AluF  in  4  ALU result, combinational from AluA/AluB/AluS.
- Busy  out  1  high in FETCH and EXEC.
- Done  out  1  one-cycle pulse when an instruction completes.
- Err  out  1  one-cycle pulse with Done for an illegal opcode.
- Result  out  4  last value written to a register; holds until the next write.
- Z  out  1  zero flag (see Configuration).

## Operation
- Opcodes:
  - 000 MV: Rx <= Ry.
  - 001 MVI: Rx <= Din.
  - 010 ADD: Rx <= Rx+Ry.
  - 011 SUB: Rx <= Rx-Ry.
  - 100 AND: Rx <= Rx&Ry.
  - 101 NOT: Rx <= AluF with S=11.
  - 110, 111: illegal.
- NOT result is taken verbatim from AluF; the ALU performs a logical not, so the result is 4'h1 if Rx==0, else 4'h0.
- Arithmetic is mod 16. Carry and borrow are dropped; there is no overflow flag.
- States: IDLE, FETCH, EXEC, DONE.
  - IDLE/DONE, Run=1: latch Instr and Din, go to FETCH.
  - IDLE/DONE, Run=0: go to IDLE.
  - FETCH, ALU op: AluA <= R[Rx], AluB <= R[Ry], AluS <= op code; go to EXEC.
  - FETCH, MV/MVI: R[Rx] and Result <= source; go to DONE.
  - FETCH, illegal: no write, Err is set for DONE; go to DONE.
  - EXEC: R[Rx] <= AluF, Result <= AluF; go to DONE.
  - DONE: Done=1, Err as set; same transitions as IDLE.
- Run is ignored while Busy=1. Instr and Din may change freely once accepted.
- Rx==Ry is legal: both operands read the same register (e.g. SUB R2,R2 gives 0).
- Reset, at any state including mid-EXEC:
  - state <= IDLE; all registers, AluA, AluB, AluS, Result and Z <= 0; Done, Err, Busy <= 0.
  - An in-flight instruction is abandoned with no writeback.

## Timing
- Run accepted at the end of cycle 0.
- ALU op: FETCH in cycle 1, EXEC in cycle 2, Done in cycle 3. Register and Result already updated when Done is seen.
- MV/MVI/illegal: FETCH in cycle 1, Done in cycle 2.
- Back-to-back: Run held high during DONE is accepted; the next FETCH follows immediately. Throughput is one ALU op per 3 cycles.
- AluF must settle within one cycle of AluA/AluB/AluS changing. The ALU is purely combinational.

## Configuration
- ALU_SEQ_FLAGS_EN:
  - Defined: Z is a register updated on every register write, Z <= (written value == 0). It holds otherwise and resets to 0.
  - Undefined: Z is tied to 0 and the flag register is not built.

## Structure
- Shared package alu_seq_pkg holds:
  - opcode constants OP_MV..OP_NOT;
  - ALU select constants SEL_ADD=00, SEL_SUB=01, SEL_AND=10, SEL_NOT=11;
  - state encoding.
- One sub-module, regfile4x4:
  - two combinational read ports, one synchronous write port;
  - synchronous active-high reset clears all four registers to 0.
- The ALU is instantiated outside this block in the top-level.

## Test plan
- After reset, MVI R1,5 then MVI R2,3 then ADD R1,R2 -> ADD gives Done in cycle 3, Result=4'h8, AluS=00, Busy high for 2 cycles.
- With R1=3, R2=5: SUB R1,R2 -> Result=4'hE (wrap). Then AND R1,R2 (E&5) -> Result=4'h4; with flags enabled Z=0.
- NOT R3 with R3=0 -> Result=4'h1. NOT R3 again -> Result=4'h0; with flags enabled Z=1, without Z=0.
- Opcode 110 -> Done and Err pulse together in cycle 2; all registers and Result unchanged.
- Run pulsed during FETCH/EXEC -> ignored, exactly one Done. Run held high through DONE -> next instruction FETCH on the following cycle.
- Reset asserted in EXEC of ADD -> next cycle: IDLE, Result=0, all registers 0, no Done pulse.
